pc_redirect_ctrl: RTL and testbench

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/pc_redirect_ctrl.sv | 130 +++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - fetch PC register with EX-stage branch redirect and stall-deferred target.
// Optional branch statistics counters are enabled by defining BR_STAT_EN.
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall,
  input  logic        ex_valid,
  input  logic [1:0]  ex_br_type,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_pc_add4,
  input  logic [31:0] ex_offset,
  output logic [31:0] pc,
  output logic [1:0]  npc_sel,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        redirect_pending,
  output logic [31:0] br_cnt,
  output logic [31:0] br_taken_cnt
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [1:0]  pend_sel_q, pend_sel_d;
  logic        redirect;
  logic        accept;
  logic [31:0] target;

  assign redirect = ex_valid && ((ex_br_type == 2'b01) || (ex_br_type == 2'b10) ||
                                 ((ex_br_type == 2'b11) && ex_br_taken));

  always_comb begin
    target = 32'h0;
    case (ex_br_type)
      2'b01:   target = ex_pc_add4 + ex_offset;
      2'b10:   target = ex_offset;
      2'b11:   target = ex_pc_add4 + ex_offset - 32'd4;
      default: target = 32'h0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    pend_sel_d  = pend_sel_q;
    npc_sel     = 2'b00;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    accept      = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (redirect) begin
            accept      = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            if (!if_stall) begin
              pc_d    = target;
              npc_sel = ex_br_type;
            end else begin
              pend_pc_d  = target;
              pend_sel_d = ex_br_type;
              state_d    = HOLD;
            end
          end else if (!if_stall) begin
            pc_d = pc_q + 32'd4;
          end
        end
        HOLD: begin
          // EX inputs are ignored here; the deferred target is the only source.
          if (!if_stall) begin
            pc_d       = pend_pc_q;
            npc_sel    = pend_sel_q;
            pend_pc_d  = 32'h0;
            pend_sel_d = 2'b00;
            state_d    = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pend_pc_q  <= 32'h0;
      pend_sel_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_sel_q <= pend_sel_d;
    end
  end

  assign pc               = pc_q;
  assign redirect_pending = (state_q == HOLD);

`ifdef BR_STAT_EN
  logic [31:0] br_cnt_q, br_taken_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q       <= 32'h0;
      br_taken_cnt_q <= 32'h0;
    end else begin
      if (ex_valid && (ex_br_type != 2'b00) && (state_q == RUN))
        br_cnt_q <= br_cnt_q + 32'd1;
      if (accept)
        br_taken_cnt_q <= br_taken_cnt_q + 32'd1;
    end
  end

  assign br_cnt       = br_cnt_q;
  assign br_taken_cnt = br_taken_cnt_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign br_cnt        = 32'h0;
  assign br_taken_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed self-checking bench for pc_redirect_ctrl.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall;
  logic        ex_valid;
  logic [1:0]  ex_br_type;
  logic        ex_br_taken;
  logic [31:0] ex_pc_add4;
  logic [31:0] ex_offset;
  logic [31:0] pc;
  logic [1:0]  npc_sel;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        redirect_pending;
  logic [31:0] br_cnt;
  logic [31:0] br_taken_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.RESET_PC(32'h1c000000)) dut (
    .clk(clk), .rst(rst), .if_stall(if_stall), .ex_valid(ex_valid),
    .ex_br_type(ex_br_type), .ex_br_taken(ex_br_taken), .ex_pc_add4(ex_pc_add4),
    .ex_offset(ex_offset), .pc(pc), .npc_sel(npc_sel), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .redirect_pending(redirect_pending),
    .br_cnt(br_cnt), .br_taken_cnt(br_taken_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic flushes(input string tag, input logic exp);
    check({tag, "_flush_if_id"}, {31'b0, flush_if_id}, {31'b0, exp});
    check({tag, "_flush_id_ex"}, {31'b0, flush_id_ex}, {31'b0, exp});
  endtask

  task automatic counters(input string tag, input int b, input int t);
`ifdef BR_STAT_EN
    check({tag, "_br_cnt"}, br_cnt, b);
    check({tag, "_br_taken_cnt"}, br_taken_cnt, t);
`else
    check({tag, "_br_cnt"}, br_cnt, 32'h0);
    check({tag, "_br_taken_cnt"}, br_taken_cnt, 32'h0);
    if (b < 0 || t < 0) $display("negative count");
`endif
  endtask

  task automatic ex(input logic v, input logic [1:0] ty, input logic tk,
                    input logic [31:0] a4, input logic [31:0] off);
    ex_valid    = v;
    ex_br_type  = ty;
    ex_br_taken = tk;
    ex_pc_add4  = a4;
    ex_offset   = off;
  endtask

  initial begin
    rst = 1'b1;
    if_stall = 1'b0;
    ex(1'b1, 2'b11, 1'b1, 32'h1c000014, 32'h10);
    settle();
    check("rst_npc_sel", {30'b0, npc_sel}, 32'h0);
    flushes("rst", 1'b0);
    step();
    check("rst_pc", pc, 32'h1c000000);
    check("rst_pending", {31'b0, redirect_pending}, 32'h0);
    counters("rst", 0, 0);

    rst = 1'b0;
    ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    settle();
    check("seq0", pc, 32'h1c000000);
    check("seq0_npc_sel", {30'b0, npc_sel}, 32'h0);
    step(); check("seq1", pc, 32'h1c000004);
    step(); check("seq2", pc, 32'h1c000008);
    step(); check("seq3", pc, 32'h1c00000c);

    ex(1'b1, 2'b11, 1'b1, 32'h1c000014, 32'h00000010);
    settle();
    flushes("bcc_taken", 1'b1);
    check("bcc_taken_npc_sel", {30'b0, npc_sel}, 32'h3);
    step();
    check("bcc_taken_pc", pc, 32'h1c000020);
    counters("bcc_taken", 1, 1);

    ex(1'b1, 2'b11, 1'b0, 32'h1c000024, 32'h00000040);
    settle();
    flushes("bcc_not", 1'b0);
    check("bcc_not_npc_sel", {30'b0, npc_sel}, 32'h0);
    step();
    check("bcc_not_pc", pc, 32'h1c000024);
    counters("bcc_not", 2, 1);

    ex(1'b0, 2'b01, 1'b0, 32'h1c000028, 32'h00000100);
    settle();
    flushes("invalid", 1'b0);
    step();
    check("invalid_pc", pc, 32'h1c000028);
    counters("invalid", 2, 1);

    if_stall = 1'b1;
    ex(1'b1, 2'b10, 1'b0, 32'h1c00002c, 32'h1c000100);
    settle();
    flushes("stall_br", 1'b1);
    check("stall_br_npc_sel", {30'b0, npc_sel}, 32'h0);
    check("stall_br_pending0", {31'b0, redirect_pending}, 32'h0);
    step();
    check("hold1_pc", pc, 32'h1c000028);
    check("hold1_pending", {31'b0, redirect_pending}, 32'h1);
    counters("hold1", 3, 2);
    ex(1'b1, 2'b01, 1'b0, 32'h00000000, 32'h00000000);
    settle();
    flushes("hold_ignore", 1'b0);
    step();
    check("hold2_pc", pc, 32'h1c000028);
    check("hold2_pending", {31'b0, redirect_pending}, 32'h1);
    if_stall = 1'b0;
    settle();
    check("release_npc_sel", {30'b0, npc_sel}, 32'h2);
    flushes("release", 1'b0);
    step();
    check("release_pc", pc, 32'h1c000100);
    check("release_pending", {31'b0, redirect_pending}, 32'h0);
    counters("release", 3, 2);
    ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();
    check("after_release_pc", pc, 32'h1c000104);

    if_stall = 1'b1;
    ex(1'b1, 2'b10, 1'b0, 32'h1c000108, 32'h1c000100);
    step();
    check("hold_b_pending", {31'b0, redirect_pending}, 32'h1);
    ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    if_stall = 1'b0;
    settle();
    check("rst_hold_npc_sel", {30'b0, npc_sel}, 32'h0);
    step();
    check("rst_hold_pc", pc, 32'h1c000000);
    check("rst_hold_pending", {31'b0, redirect_pending}, 32'h0);
    counters("rst_hold", 0, 0);
    rst = 1'b0;
    step(); check("post_rst1", pc, 32'h1c000004);
    step(); check("post_rst2", pc, 32'h1c000008);

    ex(1'b1, 2'b01, 1'b0, 32'hfffffffc, 32'h00000008);
    settle();
    check("jirl_npc_sel", {30'b0, npc_sel}, 32'h1);
    flushes("jirl", 1'b1);
    step();
    check("jirl_wrap_pc", pc, 32'h00000004);

    ex(1'b1, 2'b10, 1'b0, 32'h00000008, 32'hfffffffc);
    step();
    check("b_top_pc", pc, 32'hfffffffc);
    ex(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    step();
    check("pc_wrap", pc, 32'h00000000);
    counters("end", 2, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
